// File: rtl/v_dff_en.sv
// ---------------------------------------------------------------------------
// v_dff_en -- n-bit D register with synchronous active-low reset and load
// enable.
//
// Holding register for pipeline stages that must freeze while stalled but
// still clear on a flush, e.g. the writeback-stage delayed-branch flag that
// holds while fetch is stalled. This is the reset-capable sibling of the
// plain enable register.
//
// Parameters
//   n        data width in bits (>= 1); first parameter so #16 overrides it
//   RST_VAL  value loaded on reset, sized to n bits (default all zeros)
//
// Ports (positional order fixed: clk, rst, en, in, out)
//   clk  in   1  clock, all state changes on the rising edge
//   rst  in   1  synchronous reset, active-low
//   en   in   1  load enable: 1 = capture in, 0 = hold
//   in   in   n  data input
//   out  out  n  registered data output (no combinational path from inputs)
// ---------------------------------------------------------------------------
module v_dff_en #(
  parameter int             n       = 1,
  parameter logic [n-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [n-1:0] in,
  output logic [n-1:0] out
);

  // A zero or negative width cannot describe a register; stop elaboration.
  generate
    if (n < 1) begin : g_width_check
      $error("v_dff_en: parameter n must be >= 1");
    end
  endgenerate

  logic [n-1:0] q;

  // Register stage: reset has priority over the load enable. The hold path
  // uses a conditional operator rather than an if so that an unknown en
  // merges in and q bitwise, leaving X wherever they differ instead of
  // quietly choosing the hold branch in simulation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= RST_VAL;
    end else begin
      q <= en ? in : q;
    end
  end

  assign out = q;

endmodule

// File: tb/tb_v_dff_en.sv
// ---------------------------------------------------------------------------
// tb_v_dff_en -- scoreboard bench for v_dff_en.
//
// Three instances share the control inputs: a 16-bit register with default
// reset value, a 1-bit register, and an 8-bit register with a non-zero reset
// value. On every rising edge a reference model applies the register rules
// (reset wins, else load when enabled, else hold) to the sampled inputs and
// pushes the expected outputs into a queue; a separate monitor pops one entry
// shortly after each edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_v_dff_en;

  localparam logic [7:0] RV8 = 8'h5A;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] din16;
  logic [0:0]  din1;
  logic [7:0]  din8;
  logic [15:0] out16;
  logic [0:0]  out1;
  logic [7:0]  out8;

  v_dff_en #(.n(16)) dut16 (
    .clk (clk), .rst (rst), .en (en), .in (din16), .out (out16)
  );

  v_dff_en #(.n(1)) dut1 (
    .clk (clk), .rst (rst), .en (en), .in (din1), .out (out1)
  );

  v_dff_en #(.n(8), .RST_VAL(RV8)) dut8 (
    .clk (clk), .rst (rst), .en (en), .in (din8), .out (out8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] e16;
    logic [0:0]  e1;
    logic [7:0]  e8;
    bit          known;
  } exp_t;

  exp_t sb[$];

  int n_cmp  = 0;
  int n_fail = 0;
  bit stim_done = 0;

  // Reference model state: plain values plus a flag saying whether the
  // register has been given a defined value yet (reset or load).
  logic [15:0] m16;
  logic [0:0]  m1;
  logic [7:0]  m8;
  bit          m_known = 0;

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst === 1'b0) begin
        m16 = 16'h0000;
        m1  = 1'b0;
        m8  = RV8;
        m_known = 1;
      end else if (en === 1'b1) begin
        m16 = din16;
        m1  = din1;
        m8  = din8;
        m_known = 1;
      end
      e.e16 = m16;
      e.e1  = m1;
      e.e8  = m8;
      e.known = m_known;
      sb.push_back(e);
    end
  end

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: one output per edge, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.known) begin
          check16("out16", out16, e.e16);
          check16("out1", {15'b0, out1}, {15'b0, e.e1});
          check16("out8", {8'b0, out8}, {8'b0, e.e8});
        end
      end
    end
  end

  task automatic step(input logic r, input logic e, input logic [15:0] d);
    @(negedge clk);
    rst   = r;
    en    = e;
    din16 = d;
    din1  = d[0];
    din8  = d[7:0];
  endtask

  // Drop rst low and raise it again entirely between two rising edges.
  task automatic glitch_rst();
    @(negedge clk);
    #1 rst = 1'b0;
    #2 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; din16 = '0; din1 = '0; din8 = '0;
    repeat (2) @(negedge clk);

    // Reset with en=1 and all-ones data: reset value must win.
    step(1'b0, 1'b1, 16'hFFFF);
    // Load 1, then hold with en=0 for 5 edges, then load 0.
    step(1'b1, 1'b1, 16'h0001);
    repeat (5) step(1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 16'h0000);
    // Reset priority over a simultaneous load.
    step(1'b1, 1'b1, 16'hA5A5);
    step(1'b0, 1'b1, 16'h1234);
    // Reset pulse between edges with out==1 has no effect.
    step(1'b1, 1'b1, 16'h0001);
    step(1'b1, 1'b0, 16'h0000);
    glitch_rst();
    step(1'b1, 1'b0, 16'h0000);
    // Reset while stalled, then reload.
    step(1'b1, 1'b1, 16'h00FF);
    step(1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 16'h0F0F);
    step(1'b1, 1'b0, 16'hFFFF);

    // Randomised traffic: occasional resets, ~50% enable, random data,
    // with some long stalls mixed in.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        for (int k = 0; k < 12; k++)
          step(1'b1, 1'b0, 16'($urandom));
      end else if ($urandom_range(0, 15) == 0) begin
        glitch_rst();
      end else begin
        step(($urandom_range(0, 9) != 0), 1'($urandom), 16'($urandom));
      end
    end

    stim_done = 1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (sb.size() > 1) begin
      n_fail++;
      $display("FAIL drain: %0d scoreboard entries left, expected at most 1", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Safety bound on the whole run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time exceeded, stim_done=%0d expected 1", stim_done);
    $fatal(1, "timeout");
  end

endmodule
